// File: rtl/bp_pkg.sv
// bp_pkg: shared types, counter encodings and saturating-counter update for the branch predictor
package bp_pkg;
    localparam int BP_IDX_W = 4;
    typedef logic [1:0] ctr_t;
    localparam ctr_t SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3;
    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                pred;
    } inflight_t;
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        return taken ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
    endfunction
endpackage

// File: rtl/bp_inflight_fifo.sv
// bp_inflight_fifo: in-order queue of outstanding predictions with flush and occupancy count
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  inflight_t     din,
    output inflight_t     head,
    output logic [CW-1:0] count
);
    inflight_t mem [DEPTH];
    logic [PW-1:0] wp, rp;
    assign head = mem[rp];
    always_ff @(posedge clk)
        if (push && !flush) mem[wp] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
endmodule

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: 2-bit counter table serving lookups, tracking in-flight predictions
// and retiring resolved outcomes in order with mispredict/orphan reporting
module branch_pred_ctrl
    import bp_pkg::*;
#(
    parameter int   IDX_W    = BP_IDX_W,
    parameter int   DEPTH    = 4,
    parameter ctr_t CTR_INIT = 2'b11,
    localparam int  CW       = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_idx,
    output logic             req_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic             flush,
    output logic             mispredict,
    output logic             res_orphan,
    output logic [CW-1:0]    inflight_cnt
);
    ctr_t ctr [2**IDX_W];
    inflight_t head;
    logic push, pop, pred;
    logic [IDX_W-1:0] hidx;
    ctr_t upd;
    assign req_ready = (inflight_cnt < CW'(DEPTH)) && !flush;
    assign push = req_valid && req_ready;
    assign pop = res_valid && (inflight_cnt != '0) && !flush;
    assign hidx = head.idx[IDX_W-1:0];
    assign upd = ctr_next(ctr[hidx], res_taken);
    // a lookup hitting the counter being retired this cycle sees the updated value
    assign pred = (pop && hidx == req_idx) ? upd[1] : ctr[req_idx][1];
    bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ('{idx: BP_IDX_W'(req_idx), pred: pred}),
        .head  (head),
        .count (inflight_cnt)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < 2**IDX_W; i++) ctr[i] <= CTR_INIT;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
            res_orphan <= 1'b0;
        end else begin
            if (pop) ctr[hidx] <= upd;
            pred_valid <= push;
            pred_taken <= push && pred;
            mispredict <= pop && (head.pred != res_taken);
            res_orphan <= res_valid && (inflight_cnt == '0) && !flush;
        end
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: directed vector table, async-reset sequence and randomized run
// against a queue/array reference model of the predictor
module tb_branch_pred_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, res_valid = 1'b0, res_taken = 1'b0, flush = 1'b0;
    logic [3:0] req_idx = '0;
    logic req_ready, pred_valid, pred_taken, mispredict, res_orphan;
    logic [2:0] inflight_cnt;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    branch_pred_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .res_valid(res_valid),
        .res_taken(res_taken), .flush(flush), .mispredict(mispredict),
        .res_orphan(res_orphan), .inflight_cnt(inflight_cnt)
    );

    typedef struct {int rv, ri, sv, st, fl, rdy, pv, pt, mis, orph, cnt;} vec_t;
    typedef struct {int idx; int pred;} ent_t;
    vec_t tv[31];
    int mctr[16];
    ent_t mq[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int rv, input int ri, input int sv, input int st, input int fl);
        req_valid = 1'(rv); req_idx = 4'(ri); res_valid = 1'(sv); res_taken = 1'(st); flush = 1'(fl);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 16; i++) mctr[i] = 3;
        mq.delete();
    endtask

    task automatic model_step(input int rv, input int ri, input int sv, input int st, input int fl,
                              output int rdy, output int pv, output int pt, output int mis,
                              output int orph, output int cnt);
        ent_t h;
        rdy = (mq.size() < 4 && fl == 0) ? 1 : 0;
        pv = rv & rdy;
        mis = 0;
        orph = (sv == 1 && mq.size() == 0 && fl == 0) ? 1 : 0;
        if (sv == 1 && mq.size() > 0 && fl == 0) begin
            h = mq.pop_front();
            mis = (h.pred != st) ? 1 : 0;
            mctr[h.idx] = st ? ((mctr[h.idx] < 3) ? mctr[h.idx] + 1 : 3)
                             : ((mctr[h.idx] > 0) ? mctr[h.idx] - 1 : 0);
        end
        pt = (pv == 1 && mctr[ri] >= 2) ? 1 : 0;
        if (pv == 1) mq.push_back('{ri, pt});
        if (fl == 1) mq.delete();
        cnt = mq.size();
    endtask

    initial begin
        int rdy, pv, pt, mis, orph, cnt, rv, ri, sv, st, fl;
        tv = '{
            '{1,5,0,0,0, 1,1,1,0,0,1}, '{0,0,1,1,0, 1,0,0,0,0,0},
            '{1,3,0,0,0, 1,1,1,0,0,1}, '{1,3,1,0,0, 1,1,1,1,0,1},
            '{1,3,1,0,0, 1,1,0,1,0,1}, '{1,3,1,0,0, 1,1,0,0,0,1},
            '{0,0,1,0,0, 1,0,0,0,0,0}, '{1,3,0,0,0, 1,1,0,0,0,1},
            '{0,0,1,0,0, 1,0,0,0,0,0}, '{1,3,0,0,0, 1,1,0,0,0,1},
            '{0,0,1,1,0, 1,0,0,1,0,0}, '{1,0,0,0,0, 1,1,1,0,0,1},
            '{1,1,0,0,0, 1,1,1,0,0,2}, '{1,2,0,0,0, 1,1,1,0,0,3},
            '{1,4,0,0,0, 1,1,1,0,0,4}, '{1,6,1,1,0, 0,0,0,0,0,3},
            '{0,0,1,1,0, 1,0,0,0,0,2}, '{0,0,1,0,0, 1,0,0,1,0,1},
            '{1,2,1,1,0, 1,1,1,0,0,1}, '{1,2,1,0,0, 1,1,0,1,0,1},
            '{0,0,1,0,0, 1,0,0,0,0,0}, '{0,0,1,1,0, 1,0,0,0,1,0},
            '{0,0,0,0,0, 1,0,0,0,0,0}, '{1,7,0,0,0, 1,1,1,0,0,1},
            '{1,8,0,0,0, 1,1,1,0,0,2}, '{1,9,0,0,0, 1,1,1,0,0,3},
            '{1,10,1,0,1, 0,0,0,0,0,0}, '{1,7,0,0,0, 1,1,1,0,0,1},
            '{0,0,1,0,1, 0,0,0,0,0,0}, '{1,0,0,0,0, 1,1,1,0,0,1},
            '{0,0,1,1,0, 1,0,0,0,0,0}
        };
        repeat (2) @(posedge clk);
        #1;
        check("rst_pred_valid", 8'(pred_valid), 0);
        check("rst_pred_taken", 8'(pred_taken), 0);
        check("rst_mispredict", 8'(mispredict), 0);
        check("rst_orphan", 8'(res_orphan), 0);
        check("rst_cnt", 8'(inflight_cnt), 0);
        check("rst_ready", 8'(req_ready), 1);
        rst = 1'b0;
        tick();
        foreach (tv[i]) begin
            drive(tv[i].rv, tv[i].ri, tv[i].sv, tv[i].st, tv[i].fl);
            #1;
            check($sformatf("vec%0d_ready", i), 8'(req_ready), 8'(tv[i].rdy));
            tick();
            check($sformatf("vec%0d_pred_valid", i), 8'(pred_valid), 8'(tv[i].pv));
            if (tv[i].pv == 1) check($sformatf("vec%0d_pred_taken", i), 8'(pred_taken), 8'(tv[i].pt));
            check($sformatf("vec%0d_mispredict", i), 8'(mispredict), 8'(tv[i].mis));
            check($sformatf("vec%0d_orphan", i), 8'(res_orphan), 8'(tv[i].orph));
            check($sformatf("vec%0d_cnt", i), 8'(inflight_cnt), 8'(tv[i].cnt));
        end
        // idx 3 sits at WNT here; build a pending mispredict, then reset between edges
        drive(1, 3, 0, 0, 0);
        tick();
        check("ar_pre_pred", 8'(pred_taken), 0);
        drive(1, 3, 1, 1, 0);
        tick();
        check("ar_pre_mis", 8'(mispredict), 1);
        check("ar_pre_fwd", 8'(pred_taken), 1);
        #2 rst = 1'b1;
        #1;
        check("ar_pred_valid", 8'(pred_valid), 0);
        check("ar_pred_taken", 8'(pred_taken), 0);
        check("ar_mispredict", 8'(mispredict), 0);
        check("ar_cnt", 8'(inflight_cnt), 0);
        check("ar_ready", 8'(req_ready), 1);
        drive(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(1, 3, 0, 0, 0);
        tick();
        check("ar_init_idx3", 8'(pred_taken), 1);
        drive(1, 2, 0, 0, 0);
        tick();
        check("ar_init_idx2", 8'(pred_taken), 1);
        check("ar_cnt_after", 8'(inflight_cnt), 2);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            rv = ($urandom_range(0, 9) < 6) ? 1 : 0;
            ri = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            sv = ($urandom_range(0, 1) == 1) ? 1 : 0;
            st = $urandom_range(0, 1);
            fl = ($urandom_range(0, 19) == 0) ? 1 : 0;
            drive(rv, ri, sv, st, fl);
            #1;
            model_step(rv, ri, sv, st, fl, rdy, pv, pt, mis, orph, cnt);
            check("rnd_ready", 8'(req_ready), 8'(rdy));
            tick();
            check("rnd_pred_valid", 8'(pred_valid), 8'(pv));
            if (pv == 1) check("rnd_pred_taken", 8'(pred_taken), 8'(pt));
            check("rnd_mispredict", 8'(mispredict), 8'(mis));
            check("rnd_orphan", 8'(res_orphan), 8'(orph));
            check("rnd_cnt", 8'(inflight_cnt), 8'(cnt));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
